// File: rtl/bus_xbar.sv
// Two-master read / one-master write crossbar onto SLAVE_NUM slaves.
// Reads are granted combinationally and acked one cycle later from a pending register.
module bus_xbar #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int FETCH_WIDTH       = 2,
    parameter int SIZE_WIDTH        = 3,
    parameter int SLAVE_NUM         = 2,
    parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h2000_0000, 32'h0000_0000},
    parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_0000, 32'hFFF0_0000},
    localparam int BUS_DATA_WIDTH = INSTRUCTION_WIDTH * FETCH_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            fetch_bus_addr,
    input  logic                             fetch_bus_read_req,
    output logic [BUS_DATA_WIDTH-1:0]        bus_fetch_data,
    output logic                             bus_fetch_read_ack,
    output logic                             bus_fetch_err,
    input  logic [ADDR_WIDTH-1:0]            stbuf_bus_read_addr,
    input  logic [SIZE_WIDTH-1:0]            stbuf_bus_read_size,
    input  logic                             stbuf_bus_read_req,
    input  logic [ADDR_WIDTH-1:0]            stbuf_bus_write_addr,
    input  logic [SIZE_WIDTH-1:0]            stbuf_bus_write_size,
    input  logic [DATA_WIDTH-1:0]            stbuf_bus_data,
    input  logic                             stbuf_bus_write_req,
    output logic [DATA_WIDTH-1:0]            bus_stbuf_data,
    output logic                             bus_stbuf_read_ack,
    output logic                             bus_stbuf_write_ack,
    output logic                             bus_stbuf_read_err,
    output logic                             bus_stbuf_write_err,
    output logic [SLAVE_NUM*ADDR_WIDTH-1:0]  bus_slv_read_addr,
    output logic [SLAVE_NUM*SIZE_WIDTH-1:0]  bus_slv_read_size,
    output logic [SLAVE_NUM-1:0]             bus_slv_rd,
    output logic [SLAVE_NUM*ADDR_WIDTH-1:0]  bus_slv_write_addr,
    output logic [SLAVE_NUM*SIZE_WIDTH-1:0]  bus_slv_write_size,
    output logic [SLAVE_NUM*DATA_WIDTH-1:0]  bus_slv_data,
    output logic [SLAVE_NUM-1:0]             bus_slv_wr,
    input  logic [SLAVE_NUM*BUS_DATA_WIDTH-1:0] slv_bus_data
);

    localparam int IW = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
    localparam logic [SIZE_WIDTH-1:0] FETCH_SIZE = SIZE_WIDTH'(BUS_DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BUS_DATA_WIDTH / 8 - 1);
    localparam logic [SIZE_WIDTH-1:0] SZ1 = SIZE_WIDTH'(1);
    localparam logic [SIZE_WIDTH-1:0] SZ2 = SIZE_WIDTH'(2);
    localparam logic [SIZE_WIDTH-1:0] SZ4 = SIZE_WIDTH'(4);

    // Scan high to low so the lowest matching index is the one kept.
    function automatic logic [IW:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [IW:0] r;
        r = '0;
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if ((a & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    function automatic logic size_ok(input logic [SIZE_WIDTH-1:0] s);
        return (s == SZ1) || (s == SZ2) || (s == SZ4);
    endfunction

    logic          f_hit, s_hit, w_hit;
    logic [IW-1:0] f_idx, s_idx, w_idx;
    logic          f_err, s_err, w_err;
    logic          f_go, s_go, w_go;
    logic          conflict, f_grant, s_grant;

    logic                  prio_q;
    logic                  f_vld_q, f_err_q;
    logic [IW-1:0]         f_idx_q;
    logic                  s_vld_q, s_err_q;
    logic [IW-1:0]         s_idx_q;
    logic [SIZE_WIDTH-1:0] s_size_q;
    logic                  w_ack_q, w_err_q;
    logic [DATA_WIDTH-1:0] s_raw;

    assign {f_hit, f_idx} = decode(fetch_bus_addr);
    assign {s_hit, s_idx} = decode(stbuf_bus_read_addr);
    assign {w_hit, w_idx} = decode(stbuf_bus_write_addr);

    assign f_err = !f_hit || ((fetch_bus_addr & ALIGN_MASK) != '0);
    assign s_err = !s_hit || !size_ok(stbuf_bus_read_size);
    assign w_err = !w_hit || !size_ok(stbuf_bus_write_size);

    assign f_go = rst && fetch_bus_read_req && !f_err;
    assign s_go = rst && stbuf_bus_read_req && !s_err;
    assign w_go = rst && stbuf_bus_write_req && !w_err;

    // prio_q = 1 favours fetch; the loser simply keeps its request up.
    assign conflict = f_go && s_go && (f_idx == s_idx);
    assign f_grant  = f_go && (!conflict || prio_q);
    assign s_grant  = s_go && (!conflict || !prio_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q   <= 1'b0;
            f_vld_q  <= 1'b0;
            f_err_q  <= 1'b0;
            f_idx_q  <= '0;
            s_vld_q  <= 1'b0;
            s_err_q  <= 1'b0;
            s_idx_q  <= '0;
            s_size_q <= '0;
            w_ack_q  <= 1'b0;
            w_err_q  <= 1'b0;
        end else begin
            f_vld_q  <= fetch_bus_read_req && (f_err || f_grant);
            f_err_q  <= f_err;
            f_idx_q  <= f_idx;
            s_vld_q  <= stbuf_bus_read_req && (s_err || s_grant);
            s_err_q  <= s_err;
            s_idx_q  <= s_idx;
            s_size_q <= stbuf_bus_read_size;
            w_ack_q  <= stbuf_bus_write_req;
            w_err_q  <= w_err;
            if (conflict)
                prio_q <= !prio_q;
        end
    end

    always_comb begin
        bus_slv_rd         = '0;
        bus_slv_read_addr  = '0;
        bus_slv_read_size  = '0;
        bus_slv_wr         = '0;
        bus_slv_write_addr = '0;
        bus_slv_write_size = '0;
        bus_slv_data       = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (f_grant && f_idx == IW'(i)) begin
                bus_slv_rd[i] = 1'b1;
                bus_slv_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = fetch_bus_addr;
                bus_slv_read_size[i*SIZE_WIDTH +: SIZE_WIDTH] = FETCH_SIZE;
            end else if (s_grant && s_idx == IW'(i)) begin
                bus_slv_rd[i] = 1'b1;
                bus_slv_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = stbuf_bus_read_addr;
                bus_slv_read_size[i*SIZE_WIDTH +: SIZE_WIDTH] = stbuf_bus_read_size;
            end
            if (w_go && w_idx == IW'(i)) begin
                bus_slv_wr[i] = 1'b1;
                bus_slv_write_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = stbuf_bus_write_addr;
                bus_slv_write_size[i*SIZE_WIDTH +: SIZE_WIDTH] = stbuf_bus_write_size;
                bus_slv_data[i*DATA_WIDTH +: DATA_WIDTH]       = stbuf_bus_data;
            end
        end
    end

    assign bus_fetch_read_ack = f_vld_q;
    assign bus_fetch_err      = f_vld_q && f_err_q;
    assign bus_fetch_data     = (f_vld_q && !f_err_q)
        ? slv_bus_data[int'(f_idx_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;

    assign bus_stbuf_read_ack  = s_vld_q;
    assign bus_stbuf_read_err  = s_vld_q && s_err_q;
    assign bus_stbuf_write_ack = w_ack_q;
    assign bus_stbuf_write_err = w_ack_q && w_err_q;

    assign s_raw = slv_bus_data[int'(s_idx_q)*BUS_DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        bus_stbuf_data = '0;
        if (s_vld_q && !s_err_q) begin
            unique case (1'b1)
                s_size_q == SZ1: bus_stbuf_data = s_raw & DATA_WIDTH'(8'hFF);
                s_size_q == SZ2: bus_stbuf_data = s_raw & DATA_WIDTH'(16'hFFFF);
                s_size_q == SZ4: bus_stbuf_data = s_raw;
                default:         bus_stbuf_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xbar.sv
// Directed bench for bus_xbar: decode, arbitration, pipelining, errors, reset.
// Inputs change #1 after posedge; checks run after a further #1.
module tb_bus_xbar;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 64;
    localparam int SW = 3;
    localparam int N  = 2;
    localparam logic [63:0] D0 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D1 = 64'hCAFE_F00D_8765_43A5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   fetch_bus_addr;
    logic            fetch_bus_read_req;
    logic [BW-1:0]   bus_fetch_data;
    logic            bus_fetch_read_ack;
    logic            bus_fetch_err;
    logic [AW-1:0]   stbuf_bus_read_addr;
    logic [SW-1:0]   stbuf_bus_read_size;
    logic            stbuf_bus_read_req;
    logic [AW-1:0]   stbuf_bus_write_addr;
    logic [SW-1:0]   stbuf_bus_write_size;
    logic [DW-1:0]   stbuf_bus_data;
    logic            stbuf_bus_write_req;
    logic [DW-1:0]   bus_stbuf_data;
    logic            bus_stbuf_read_ack;
    logic            bus_stbuf_write_ack;
    logic            bus_stbuf_read_err;
    logic            bus_stbuf_write_err;
    logic [N*AW-1:0] bus_slv_read_addr;
    logic [N*SW-1:0] bus_slv_read_size;
    logic [N-1:0]    bus_slv_rd;
    logic [N*AW-1:0] bus_slv_write_addr;
    logic [N*SW-1:0] bus_slv_write_size;
    logic [N*DW-1:0] bus_slv_data;
    logic [N-1:0]    bus_slv_wr;
    logic [N*BW-1:0] slv_bus_data;

    int checks = 0;
    int failures = 0;

    bus_xbar dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_bus_addr       (fetch_bus_addr),
        .fetch_bus_read_req   (fetch_bus_read_req),
        .bus_fetch_data       (bus_fetch_data),
        .bus_fetch_read_ack   (bus_fetch_read_ack),
        .bus_fetch_err        (bus_fetch_err),
        .stbuf_bus_read_addr  (stbuf_bus_read_addr),
        .stbuf_bus_read_size  (stbuf_bus_read_size),
        .stbuf_bus_read_req   (stbuf_bus_read_req),
        .stbuf_bus_write_addr (stbuf_bus_write_addr),
        .stbuf_bus_write_size (stbuf_bus_write_size),
        .stbuf_bus_data       (stbuf_bus_data),
        .stbuf_bus_write_req  (stbuf_bus_write_req),
        .bus_stbuf_data       (bus_stbuf_data),
        .bus_stbuf_read_ack   (bus_stbuf_read_ack),
        .bus_stbuf_write_ack  (bus_stbuf_write_ack),
        .bus_stbuf_read_err   (bus_stbuf_read_err),
        .bus_stbuf_write_err  (bus_stbuf_write_err),
        .bus_slv_read_addr    (bus_slv_read_addr),
        .bus_slv_read_size    (bus_slv_read_size),
        .bus_slv_rd           (bus_slv_rd),
        .bus_slv_write_addr   (bus_slv_write_addr),
        .bus_slv_write_size   (bus_slv_write_size),
        .bus_slv_data         (bus_slv_data),
        .bus_slv_wr           (bus_slv_wr),
        .slv_bus_data         (slv_bus_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_bus_read_req  = 1'b0;
        stbuf_bus_read_req  = 1'b0;
        stbuf_bus_write_req = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        fetch_bus_addr     = a;
        fetch_bus_read_req = 1'b1;
    endtask

    task automatic sread(input logic [AW-1:0] a, input logic [SW-1:0] s);
        stbuf_bus_read_addr = a;
        stbuf_bus_read_size = s;
        stbuf_bus_read_req  = 1'b1;
    endtask

    task automatic swrite(input logic [AW-1:0] a, input logic [SW-1:0] s,
                          input logic [DW-1:0] d);
        stbuf_bus_write_addr = a;
        stbuf_bus_write_size = s;
        stbuf_bus_data       = d;
        stbuf_bus_write_req  = 1'b1;
    endtask

    initial begin
        slv_bus_data = {D1, D0};
        fetch_bus_addr = '0;
        stbuf_bus_read_addr = '0;
        stbuf_bus_read_size = '0;
        stbuf_bus_write_addr = '0;
        stbuf_bus_write_size = '0;
        stbuf_bus_data = '0;
        idle();

        // Requests held during reset must produce nothing
        fetch(32'h0000_0100);
        sread(32'h2000_0000, 3'd4);
        swrite(32'h2000_0008, 3'd4, 32'h1234_5678);
        #3;
        check("rst_rd", bus_slv_rd, 2'b00);
        check("rst_wr", bus_slv_wr, 2'b00);
        check("rst_slv_data", bus_slv_data, 64'h0);
        step();
        check("rst_acks", {bus_fetch_read_ack, bus_stbuf_read_ack,
              bus_stbuf_write_ack}, 3'b000);
        check("rst_fdata", bus_fetch_data, 64'h0);
        idle();
        step();
        rst = 1'b1;
        step();

        // Fetch read to slave0
        fetch(32'h0000_0100);
        #1;
        check("f_rd", bus_slv_rd, 2'b01);
        check("f_addr0", bus_slv_read_addr[31:0], 32'h0000_0100);
        step();
        idle();
        #1;
        check("f_ack", {bus_fetch_read_ack, bus_fetch_err}, 2'b10);
        check("f_data", bus_fetch_data, D0);
        check("f_rd_off", bus_slv_rd, 2'b00);
        step();
        check("idle_fack", bus_fetch_read_ack, 1'b0);
        check("idle_fdata", bus_fetch_data, 64'h0);

        // Stbuf byte/half/word reads to slave1, back-to-back
        sread(32'h2000_0004, 3'd1);
        #1;
        check("s_rd", bus_slv_rd, 2'b10);
        check("s_size1", bus_slv_read_size[5:3], 3'd1);
        step();
        stbuf_bus_read_size = 3'd2;
        #1;
        check("s_b_ack", {bus_stbuf_read_ack, bus_stbuf_read_err}, 2'b10);
        check("s_b_data", bus_stbuf_data, 32'h0000_00A5);
        check("s_pipe_rd", bus_slv_rd, 2'b10);
        step();
        stbuf_bus_read_size = 3'd4;
        #1;
        check("s_h_data", bus_stbuf_data, 32'h0000_43A5);
        step();
        idle();
        #1;
        check("s_w_data", bus_stbuf_data, 32'h8765_43A5);
        step();
        check("idle_sdata", {bus_stbuf_read_ack, bus_stbuf_read_err,
              bus_stbuf_data}, 34'h0);

        // Conflict on slave0 with reset priority: stbuf first
        fetch(32'h0000_0200);
        sread(32'h0000_0010, 3'd4);
        #1;
        check("c1_rd", bus_slv_rd, 2'b01);
        check("c1_addr", bus_slv_read_addr[31:0], 32'h0000_0010);
        step();
        stbuf_bus_read_req = 1'b0;
        #1;
        check("c1_sack", bus_stbuf_read_ack, 1'b1);
        check("c1_sdata", bus_stbuf_data, 32'h0123_4567);
        check("c1_fack", bus_fetch_read_ack, 1'b0);
        check("c1_faddr", bus_slv_read_addr[31:0], 32'h0000_0200);
        step();
        // Priority flipped: fetch wins this one
        fetch(32'h0000_0300);
        sread(32'h0000_0020, 3'd2);
        #1;
        check("c1_fack2", bus_fetch_read_ack, 1'b1);
        check("c1_fdata", bus_fetch_data, D0);
        check("c2_addr", bus_slv_read_addr[31:0], 32'h0000_0300);
        step();
        fetch_bus_read_req = 1'b0;
        #1;
        check("c2_acks", {bus_fetch_read_ack, bus_stbuf_read_ack}, 2'b10);
        check("c2_saddr", bus_slv_read_addr[31:0], 32'h0000_0020);
        step();
        idle();
        #1;
        check("c2_sack", bus_stbuf_read_ack, 1'b1);
        check("c2_sdata", bus_stbuf_data, 32'h0000_4567);

        // Different slaves in the same cycle never stall
        fetch(32'h0000_0400);
        sread(32'h2000_0000, 3'd4);
        #1;
        check("nc_rd", bus_slv_rd, 2'b11);
        step();
        idle();
        #1;
        check("nc_acks", {bus_fetch_read_ack, bus_stbuf_read_ack}, 2'b11);

        // Writes: decode miss, then good write alongside a read of same slave
        swrite(32'h3000_0000, 3'd4, 32'h1234_5678);
        #1;
        check("w_miss_wr", bus_slv_wr, 2'b00);
        step();
        idle();
        #1;
        check("w_miss_ack", {bus_stbuf_write_ack, bus_stbuf_write_err}, 2'b11);
        swrite(32'h2000_0008, 3'd4, 32'h5555_AAAA);
        sread(32'h2000_0000, 3'd4);
        #1;
        check("w_wr", bus_slv_wr, 2'b10);
        check("w_rd", bus_slv_rd, 2'b10);
        check("w_data", bus_slv_data, 64'h5555_AAAA_0000_0000);
        check("w_addr1", bus_slv_write_addr[63:32], 32'h2000_0008);
        step();
        idle();
        #1;
        check("w_ack", {bus_stbuf_write_ack, bus_stbuf_write_err}, 2'b10);
        check("w_rack", bus_stbuf_data, 32'h8765_43A5);
        step();
        check("w_ack_off", bus_stbuf_write_ack, 1'b0);

        // Alignment, size and decode errors
        fetch(32'h0000_0004);
        #1;
        check("al_rd", bus_slv_rd, 2'b00);
        step();
        idle();
        #1;
        check("al_ack", {bus_fetch_read_ack, bus_fetch_err}, 2'b11);
        check("al_data", bus_fetch_data, 64'h0);
        sread(32'h2000_0000, 3'd3);
        #1;
        check("sz_rd", bus_slv_rd, 2'b00);
        step();
        idle();
        #1;
        check("sz_ack", {bus_stbuf_read_ack, bus_stbuf_read_err}, 2'b11);
        check("sz_data", bus_stbuf_data, 32'h0);
        fetch(32'h4000_0000);
        step();
        idle();
        #1;
        check("dec_ack", {bus_fetch_read_ack, bus_fetch_err}, 2'b11);
        swrite(32'h2000_0000, 3'd3, 32'hFFFF_FFFF);
        #1;
        check("wsz_wr", bus_slv_wr, 2'b00);
        step();
        idle();
        #1;
        check("wsz_ack", {bus_stbuf_write_ack, bus_stbuf_write_err}, 2'b11);

        // Leave priority favouring fetch, then reset with a read pending
        fetch(32'h0000_0500);
        sread(32'h0000_0030, 3'd4);
        step();
        stbuf_bus_read_req = 1'b0;
        step();
        idle();
        #1;
        check("pre_fack", bus_fetch_read_ack, 1'b1);
        sread(32'h2000_0000, 3'd4);
        step();
        idle();
        rst = 1'b0;
        #1;
        check("rr_ack0", bus_stbuf_read_ack, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("rr_ack1", bus_stbuf_read_ack, 1'b0);
        step();
        check("rr_ack2", bus_stbuf_read_ack, 1'b0);
        fetch(32'h0000_0600);
        sread(32'h0000_0040, 3'd4);
        #1;
        check("rr_prio", bus_slv_read_addr[31:0], 32'h0000_0040);
        step();
        idle();
        #1;
        check("rr_acks", {bus_fetch_read_ack, bus_stbuf_read_ack}, 2'b01);
        check("rr_sdata", bus_stbuf_data, 32'h0123_4567);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
